// File: rtl/fft_out_capture_ram.sv
// Captures one FFT/IFFT output frame of 2**ADDR_WIDTH samples from a valid/ready stream into RAM,
// with a read-first synchronous read port. `define FFT_CAP_LAST_CHK_EN adds the s_last alignment checker.
module fft_out_capture_ram #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_last,
   output logic                  s_ready,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   wr_cnt,
   output logic                  frame_err
);

   localparam int unsigned        DEPTH    = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);

   typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  accept;
   logic                  arm;

   assign accept = s_valid & s_ready;
   assign arm    = start && (state == IDLE || state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         s_ready <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         wr_cnt  <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state   <= CAPTURE;
                  s_ready <= 1'b1;
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  wr_cnt  <= '0;
               end
            end
            CAPTURE: begin
               if (accept) begin
                  wr_cnt <= wr_cnt + CNT_ONE;
                  // Final accept: ready drops and done rises on the same edge as wr_cnt hits DEPTH
                  if (wr_cnt == LAST_IDX) begin
                     state   <= DONE;
                     s_ready <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               s_ready <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wr_cnt[ADDR_WIDTH-1:0]] <= s_data;
   end

   // Non-blocking read of the array gives read-first behaviour on a same-address collision
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

`ifdef FFT_CAP_LAST_CHK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) frame_err <= 1'b0;
      else if (arm) frame_err <= 1'b0;
      else if (accept && (s_last != (wr_cnt == LAST_IDX))) frame_err <= 1'b1;
   end
`else
   logic unused_s_last;
   logic unused_arm;
   assign unused_s_last = s_last;
   assign unused_arm    = arm;
   assign frame_err     = 1'b0;
`endif

endmodule
